// File: rtl/fetch_inst_queue_pkg.sv
// Shared fetch-queue definitions: default widths, default depth and the
// {pc,inst} entry type that the fetch stage reuses when talking about
// queued instructions.
package fetch_inst_queue_pkg;

   localparam int ADDR_WIDTH        = 32;
   localparam int INST_WIDTH        = 32;
   localparam int FETCH_QUEUE_DEPTH = 4;

   // One buffered fetch result, PC in the upper half.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [INST_WIDTH-1:0] inst;
   } fetch_q_entry_t;

endpackage

// File: rtl/fetch_inst_queue.sv
// Show-ahead instruction queue between the ICache response side and decode.
// Fetch pushes {pc,inst} pairs (active-low in_e_), decode sees the head entry
// combinationally and pops it when not stalled. A commit flush empties the
// whole queue. Full is taken from the registered count only, so a push while
// full is dropped even if decode pops in the same cycle.
module fetch_inst_queue
   import fetch_inst_queue_pkg::*;
#(
   parameter int ADDR  = ADDR_WIDTH,
   parameter int INST  = INST_WIDTH,
   parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset_,
   input  logic                     flush_,
   input  logic                     in_e_,
   input  logic [ADDR-1:0]          in_pc,
   input  logic [INST-1:0]          in_inst,
   output logic                     in_full,
   output logic                     inst_e_,
   output logic [ADDR-1:0]          inst_pc,
   output logic [INST-1:0]          inst,
   input  logic                     dec_stall,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int           PTR      = $clog2(DEPTH);
   localparam logic [PTR:0] FULL_CNT = (PTR+1)'(DEPTH);

   logic [PTR-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR:0]    count_q, count_d;
   logic [ADDR-1:0] pc_mem_q   [DEPTH];
   logic [INST-1:0] inst_mem_q [DEPTH];
   logic            head_valid;
   logic            push;
   logic            pop;

   // Handshake decode and head presentation; flush masks the head instantly.
   always_comb begin
      head_valid = (count_q != '0) && flush_;
      in_full    = (count_q == FULL_CNT);
      push       = !in_e_ && !in_full && flush_;
      pop        = head_valid && !dec_stall;
      inst_e_    = !head_valid;
      inst_pc    = head_valid ? pc_mem_q[rd_ptr_q]   : '0;
      inst       = head_valid ? inst_mem_q[rd_ptr_q] : '0;
      occupancy  = count_q;
   end

   // Pointer and count next state; flush wins over push and pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (!flush_) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   // Pointer/count registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= in_pc;
         inst_mem_q[wr_ptr_q] <= in_inst;
      end
   end

   // Structural invariants of the pointer/count bookkeeping.
   always @(posedge clk) begin
      if (reset_) begin
         assert (count_q <= FULL_CNT);
         assert (!(push && in_full));
         assert ((wr_ptr_q - rd_ptr_q) == count_q[PTR-1:0]);
         if (!in_e_) assert (!$isunknown({in_pc, in_inst}));
      end
   end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Bench for fetch_inst_queue: directed sequences drive fetch/decode, every
// accepted push queues its expected {pc,inst}, and a monitor compares the
// head against that queue whenever decode pops it.
module tb_fetch_inst_queue;

   logic        clk;
   logic        reset_;
   logic        flush_;
   logic        in_e_;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        in_full;
   logic        inst_e_;
   logic [31:0] inst_pc;
   logic [31:0] inst;
   logic        dec_stall;
   logic [2:0]  occupancy;

   logic [63:0] exp_q[$];
   int          n_checks;
   int          n_errors;

   fetch_inst_queue dut (
      .clk       (clk),
      .reset_    (reset_),
      .flush_    (flush_),
      .in_e_     (in_e_),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_full   (in_full),
      .inst_e_   (inst_e_),
      .inst_pc   (inst_pc),
      .inst      (inst),
      .dec_stall (dec_stall),
      .occupancy (occupancy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [31:0] mk_inst(input logic [31:0] pc);
      return pc ^ 32'h1300_0013;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a push for one cycle; accepted pushes go on the expected queue.
   task automatic drive_push(input logic [31:0] pc, input bit accepted);
      in_e_   = 1'b0;
      in_pc   = pc;
      in_inst = mk_inst(pc);
      if (accepted) exp_q.push_back({pc, mk_inst(pc)});
      tick();
      in_e_ = 1'b1;
   endtask

   // Let decode run until every expected entry has been popped.
   task automatic drain(input string name);
      dec_stall = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (reset_ && !inst_e_ && !dec_stall) begin
         if (exp_q.size() == 0) begin
            check("pop_unexpected", {inst_pc, inst}, 64'hDEAD_DEAD_DEAD_DEAD);
         end else begin
            check("pop_data", {inst_pc, inst}, exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset_    = 1'b0;
      flush_    = 1'b1;
      in_e_     = 1'b1;
      in_pc     = '0;
      in_inst   = '0;
      dec_stall = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_ = 1'b1;
      tick();

      check("rst_inst_e", 64'(inst_e_), 64'd1);
      check("rst_full", 64'(in_full), 64'd0);
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_head", {inst_pc, inst}, 64'd0);

      // Reset mid-run with three entries held
      for (int i = 0; i < 3; i++) drive_push(32'h80 + 32'(4*i), 1'b1);
      check("mid_occ3", 64'(occupancy), 64'd3);
      reset_ = 1'b0;
      #1;
      check("mid_rst_inst_e", 64'(inst_e_), 64'd1);
      check("mid_rst_full", 64'(in_full), 64'd0);
      check("mid_rst_occ", 64'(occupancy), 64'd0);
      exp_q.delete();
      @(negedge clk);
      reset_ = 1'b1;
      tick();

      // Fill to full under stall, drop the fifth push, then drain in order
      for (int i = 0; i < 4; i++) drive_push(32'h100 + 32'(4*i), 1'b1);
      check("fill_occ", 64'(occupancy), 64'd4);
      check("fill_full", 64'(in_full), 64'd1);
      check("fill_head_pc", 64'(inst_pc), 64'h100);
      drive_push(32'h110, 1'b0);
      check("drop_occ", 64'(occupancy), 64'd4);
      drain("fill");
      check("fill_empty_inst_e", 64'(inst_e_), 64'd1);
      check("fill_empty_occ", 64'(occupancy), 64'd0);

      // Push+pop while full (push dropped), then push+pop at occupancy 2
      dec_stall = 1'b1;
      for (int i = 0; i < 4; i++) drive_push(32'h1A0 + 32'(4*i), 1'b1);
      dec_stall = 1'b0;
      drive_push(32'h200, 1'b0);
      check("simul_full_occ", 64'(occupancy), 64'd3);
      tick();
      check("simul_occ2", 64'(occupancy), 64'd2);
      drive_push(32'h204, 1'b1);
      check("simul_occ2_hold", 64'(occupancy), 64'd2);
      drain("simul");

      // Ten back-to-back push/pop pairs wrap both pointers
      dec_stall = 1'b0;
      for (int i = 0; i < 10; i++) drive_push(32'(4*i), 1'b1);
      check("wrap_occ", 64'(occupancy), 64'd1);
      drain("wrap");

      // Flush with a same-cycle push
      dec_stall = 1'b1;
      for (int i = 0; i < 3; i++) drive_push(32'h2F0 + 32'(4*i), 1'b1);
      check("flush_pre_occ", 64'(occupancy), 64'd3);
      flush_  = 1'b0;
      in_e_   = 1'b0;
      in_pc   = 32'h300;
      in_inst = mk_inst(32'h300);
      #1;
      check("flush_inst_e_comb", 64'(inst_e_), 64'd1);
      exp_q.delete();
      tick();
      flush_ = 1'b1;
      in_e_  = 1'b1;
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_inst_e", 64'(inst_e_), 64'd1);
      dec_stall = 1'b0;
      drive_push(32'h400, 1'b1);
      check("post_flush_valid", 64'(inst_e_), 64'd0);
      check("post_flush_pc", 64'(inst_pc), 64'h400);
      drain("flush");

      // Decode stall toggling on an empty queue
      for (int i = 0; i < 4; i++) begin
         dec_stall = i[0];
         tick();
         check("empty_stall_inst_e", 64'(inst_e_), 64'd1);
         check("empty_stall_occ", 64'(occupancy), 64'd0);
      end

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard time bound in case the DUT wedges the flow above.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
